// File: rtl/sap1_controller.sv
// SAP-1 controller: fetch/decode/execute sequencer plus datapath registers
// (PC, IR, accumulator, zero flag, output register) for a 16x8 memory with
// a one-clock registered read.
//
// Handshake: there is no valid/ready flow control on the memory side. When
// mem_read is high in cycle N, the memory presents mem[mem_addr] on
// mem_rdata during cycle N+1, and the controller consumes it in that cycle
// (DECODE after FETCH, EXEC after MEM). out_valid is a single-cycle pulse
// marking the cycle after out_data was loaded; the display cannot stall it.
module sap1_controller #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] mem_addr,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       halted,
    output logic [3:0] pc,
    output logic [7:0] acc,
    output logic       zero
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_MEM    = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [2:0] state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] a_q, a_d;
    logic       z_q, z_d;
    logic [7:0] out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic       halted_q, halted_d;
    logic [7:0] alu_r;

    // ALU result for the memory-operand instruction held in IR
    always_comb begin
        alu_r = a_q;
        case (ir_q[7:4])
            OP_LDA:  alu_r = mem_rdata;
            OP_ADD:  alu_r = a_q + mem_rdata;
            OP_SUB:  alu_r = a_q - mem_rdata;
            OP_AND:  alu_r = a_q & mem_rdata;
            OP_OR:   alu_r = a_q | mem_rdata;
            OP_XOR:  alu_r = a_q ^ mem_rdata;
            default: alu_r = a_q;
        endcase
    end

    // Sequencer: next state and next datapath register values
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        z_d         = z_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        halted_d    = halted_q;
        case (state_q)
            S_FETCH: begin
                pc_d    = pc_q + 4'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // IR is loaded here, so decode looks at the memory data directly
                ir_d = mem_rdata;
                case (mem_rdata[7:4])
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        state_d = S_MEM;
                    end
                    OP_JMP: begin
                        pc_d    = mem_rdata[3:0];
                        state_d = S_FETCH;
                    end
                    OP_JZ: begin
                        if (z_q) begin
                            pc_d = mem_rdata[3:0];
                        end
                        state_d = S_FETCH;
                    end
                    OP_OUT: begin
                        out_d       = a_q;
                        out_valid_d = 1'b1;
                        state_d     = S_FETCH;
                    end
                    OP_HLT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                a_d     = alu_r;
                z_d     = (alu_r == 8'h00);
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= 8'h00;
            a_q         <= 8'h00;
            z_q         <= 1'b0;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            z_q         <= z_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
        end
    end

    // Memory address and read strobe straight from state, PC and IR
    always_comb begin
        mem_read = (state_q == S_FETCH) || (state_q == S_MEM);
        mem_addr = (state_q == S_MEM) ? ir_q[3:0] : pc_q;
    end

    assign mem_write = 1'b0;
    assign mem_wdata = a_q;
    assign out_data  = out_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign pc        = pc_q;
    assign acc       = a_q;
    assign zero      = z_q;

endmodule

// File: tb/tb_sap1_controller.sv
// Testbench for sap1_controller: instruction-level reference model checked
// at instruction boundaries, directed programs and randomized programs.
module tb_sap1_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] mem_addr;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] out_data;
    logic       out_valid;
    logic       halted;
    logic [3:0] pc;
    logic [7:0] acc;
    logic       zero;

    // second instance with the reset PC at the top of memory
    logic       rst1 = 1'b1;
    logic [3:0] mem_addr1;
    logic       mem_read1;
    logic       mem_write1;
    logic [7:0] mem_wdata1;
    logic [7:0] mem_rdata1 = 8'h00;
    logic [7:0] out_data1;
    logic       out_valid1;
    logic       halted1;
    logic [3:0] pc1;
    logic [7:0] acc1;
    logic       zero1;

    logic [7:0] mem [16];
    logic [7:0] mem1 [16];
    logic       rdata_noise = 1'b0;

    int total = 0;
    int bad   = 0;

    // instruction-level model state
    logic [3:0] m_pc;
    logic [7:0] m_a;
    logic       m_z;
    logic [7:0] m_out;
    logic       m_ov;
    logic       m_halt;

    sap1_controller #(.RESET_PC(4'h0)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .halted(halted),
        .pc(pc), .acc(acc), .zero(zero)
    );

    sap1_controller #(.RESET_PC(4'hF)) dut1 (
        .clk(clk), .rst(rst1), .mem_addr(mem_addr1), .mem_read(mem_read1),
        .mem_write(mem_write1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .out_data(out_data1), .out_valid(out_valid1), .halted(halted1),
        .pc(pc1), .acc(acc1), .zero(zero1)
    );

    // clock
    always #5 clk = ~clk;

    // registered-read memories; noise mode scrambles the read data
    always @(posedge clk) begin
        if (rdata_noise) mem_rdata <= 8'($urandom);
        else if (mem_read) mem_rdata <= mem[mem_addr];
        if (mem_read1) mem_rdata1 <= mem1[mem_addr1];
    end

    task automatic model_reset();
        m_pc = 4'h0; m_a = 8'h00; m_z = 1'b0;
        m_out = 8'h00; m_ov = 1'b0; m_halt = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    task automatic load_prog1();
        logic [7:0] p [16];
        p = '{8'h0A, 8'h1B, 8'h2C, 8'h3D, 8'h4E, 8'h5F, 8'h68, 8'h70,
              8'hE0, 8'hF0, 8'h0A, 8'h05, 8'h03, 8'h0C, 8'h03, 8'h05};
        for (int i = 0; i < 16; i++) mem[i] = p[i];
    endtask

    // Execute up to max_instr instructions on the model and the DUT together
    task automatic run_program(input int max_instr, input string tag);
        logic [7:0] instr;
        logic [7:0] opnd;
        logic [7:0] r;
        logic [3:0] fpc;
        logic [3:0] n;
        for (int k = 0; k < max_instr && !m_halt; k++) begin
            fpc   = m_pc;
            instr = mem[fpc];
            n     = instr[3:0];
            total++;
            if ({mem_read, mem_addr} !== {1'b1, fpc}) begin
                bad++;
                $display("FAIL %s fetch: got read=%b addr=%h want read=1 addr=%h",
                         tag, mem_read, mem_addr, fpc);
            end
            @(posedge clk); @(negedge clk);
            m_pc = fpc + 4'd1;
            m_ov = 1'b0;
            total++;
            if ({mem_read, mem_addr} !== {1'b0, m_pc}) begin
                bad++;
                $display("FAIL %s decode: got read=%b addr=%h want read=0 addr=%h",
                         tag, mem_read, mem_addr, m_pc);
            end
            if (instr[7:4] <= 4'h5) begin
                @(posedge clk); @(negedge clk);
                total++;
                if ({mem_read, mem_addr} !== {1'b1, n}) begin
                    bad++;
                    $display("FAIL %s operand: got read=%b addr=%h want read=1 addr=%h",
                             tag, mem_read, mem_addr, n);
                end
                opnd = mem[n];
                @(posedge clk); @(negedge clk);
                case (instr[7:4])
                    4'h0:    r = opnd;
                    4'h1:    r = 8'((int'(m_a) + int'(opnd)) % 256);
                    4'h2:    r = 8'((int'(m_a) - int'(opnd) + 256) % 256);
                    4'h3:    r = m_a & opnd;
                    4'h4:    r = m_a | opnd;
                    default: r = m_a ^ opnd;
                endcase
                m_a = r;
                m_z = (r == 8'h00);
            end else begin
                case (instr[7:4])
                    4'h6: m_pc = n;
                    4'h7: if (m_z) m_pc = n;
                    4'hE: begin m_out = m_a; m_ov = 1'b1; end
                    4'hF: m_halt = 1'b1;
                    default: ;
                endcase
            end
            @(posedge clk); @(negedge clk);
            total++;
            if ({pc, acc, zero, out_data, out_valid, halted, mem_write, mem_wdata} !==
                {m_pc, m_a, m_z, m_out, m_ov, m_halt, 1'b0, m_a}) begin
                bad++;
                $display("FAIL %s state@%h op=%h: got pc=%h a=%h z=%b out=%h ov=%b h=%b w=%b wd=%h want pc=%h a=%h z=%b out=%h ov=%b h=%b w=0 wd=%h",
                         tag, fpc, instr, pc, acc, zero, out_data, out_valid, halted,
                         mem_write, mem_wdata, m_pc, m_a, m_z, m_out, m_ov, m_halt, m_a);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({pc, acc, zero, out_data, out_valid, halted, mem_read, mem_addr} !==
            {4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0}) begin
            bad++;
            $display("FAIL reset: got pc=%h a=%h z=%b out=%h ov=%b h=%b rd=%b addr=%h want 0/00/0/00/0/0/1/0",
                     pc, acc, zero, out_data, out_valid, halted, mem_read, mem_addr);
        end
    endtask

    task automatic test_program1();
        load_prog1();
        apply_reset();
        run_program(20, "prog1");
        total++;
        if ({out_data, halted, pc} !== {8'h0A, 1'b1, 4'hA}) begin
            bad++;
            $display("FAIL prog1 end: got out=%h h=%b pc=%h want out=0a h=1 pc=a",
                     out_data, halted, pc);
        end
    endtask

    task automatic test_halt_timing();
        int halt_edge;
        int pulses;
        halt_edge = 0;
        pulses = 0;
        load_prog1();
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) pulses++;
            if (halted) begin
                halt_edge = k;
                break;
            end
        end
        total++;
        if (halt_edge != 30) begin
            bad++;
            $display("FAIL halt_edge: got %0d want 30 (0 = never halted)", halt_edge);
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL out_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_halted_hold();
        rdata_noise = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); @(negedge clk);
            total++;
            if ({pc, acc, zero, out_data, mem_read, out_valid, halted} !==
                {m_pc, m_a, m_z, m_out, 1'b0, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL halt_hold cyc%0d: got pc=%h a=%h z=%b out=%h rd=%b ov=%b h=%b want pc=%h a=%h z=%b out=%h rd=0 ov=0 h=1",
                         k, pc, acc, zero, out_data, mem_read, out_valid, halted,
                         m_pc, m_a, m_z, m_out);
            end
        end
        rdata_noise = 1'b0;
    endtask

    task automatic test_jz_taken();
        clear_mem();
        mem[0] = 8'h0F; mem[1] = 8'h2F; mem[2] = 8'h75;
        mem[5] = 8'hE0; mem[6] = 8'hF0; mem[15] = 8'h07;
        apply_reset();
        run_program(10, "jz_taken");
        total++;
        if ({out_data, zero, halted, pc} !== {8'h00, 1'b1, 1'b1, 4'h7}) begin
            bad++;
            $display("FAIL jz_taken end: got out=%h z=%b h=%b pc=%h want 00/1/1/7",
                     out_data, zero, halted, pc);
        end
    endtask

    task automatic test_jz_fallthrough();
        clear_mem();
        mem[0] = 8'h0F; mem[1] = 8'h1F; mem[2] = 8'h75; mem[3] = 8'h80;
        mem[4] = 8'hF0; mem[5] = 8'hE0; mem[6] = 8'hF0; mem[15] = 8'h07;
        apply_reset();
        run_program(10, "jz_fall");
        total++;
        if ({acc, zero, halted, pc} !== {8'h0E, 1'b0, 1'b1, 4'h5}) begin
            bad++;
            $display("FAIL jz_fall end: got a=%h z=%b h=%b pc=%h want 0e/0/1/5",
                     acc, zero, halted, pc);
        end
    endtask

    task automatic test_wrap_jump();
        for (int i = 0; i < 16; i++) mem1[i] = 8'h00;
        mem1[15] = 8'h6F;
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            total++;
            if ({mem_read1, mem_addr1, pc1, acc1, zero1} !== {1'b1, 4'hF, 4'hF, 8'h00, 1'b0}) begin
                bad++;
                $display("FAIL wrap fetch%0d: got rd=%b addr=%h pc=%h a=%h z=%b want 1/f/f/00/0",
                         j, mem_read1, mem_addr1, pc1, acc1, zero1);
            end
            @(posedge clk); @(negedge clk);
            total++;
            if ({mem_read1, pc1} !== {1'b0, 4'h0}) begin
                bad++;
                $display("FAIL wrap decode%0d: got rd=%b pc=%h want rd=0 pc=0", j, mem_read1, pc1);
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_add_wrap();
        clear_mem();
        mem[0] = 8'h0E; mem[1] = 8'h1F; mem[2] = 8'hF0;
        mem[14] = 8'hFF; mem[15] = 8'h02;
        apply_reset();
        run_program(3, "add_wrap");
        total++;
        if ({acc, zero} !== {8'h01, 1'b0}) begin
            bad++;
            $display("FAIL add_wrap: got a=%h z=%b want a=01 z=0", acc, zero);
        end
    endtask

    task automatic test_reset_mid_exec();
        // memory still holds the add_wrap program: LDA [E]; ADD [F]; HLT
        apply_reset();
        repeat (4) @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({pc, acc, zero, out_data, out_valid, halted, mem_read, mem_addr} !==
            {4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0}) begin
            bad++;
            $display("FAIL mid_reset: got pc=%h a=%h z=%b out=%h ov=%b h=%b rd=%b addr=%h want 0/00/0/00/0/0/1/0",
                     pc, acc, zero, out_data, out_valid, halted, mem_read, mem_addr);
        end
        rst = 1'b0;
        model_reset();
        run_program(3, "after_reset");
    endtask

    task automatic test_reset_from_halt();
        // DUT is halted with non-zero state here
        rst = 1'b1;
        #1;
        total++;
        if ({halted, out_valid, acc, pc} !== {1'b0, 1'b0, 8'h00, 4'h0}) begin
            bad++;
            $display("FAIL reset_from_halt: got h=%b ov=%b a=%h pc=%h want 0/0/00/0",
                     halted, out_valid, acc, pc);
        end
        @(negedge clk);
    endtask

    task automatic test_random_programs();
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            // bias some slots toward control-flow and output opcodes
            mem[$urandom_range(0, 15)] = {4'hE, 4'($urandom_range(0, 15))};
            mem[$urandom_range(0, 15)] = {4'h7, 4'($urandom_range(0, 15))};
            apply_reset();
            run_program(25, "random");
        end
    endtask

    initial begin
        test_reset();
        test_program1();
        test_halted_hold();
        test_reset_from_halt();
        test_halt_timing();
        test_jz_taken();
        test_jz_fallthrough();
        test_wrap_jump();
        test_add_wrap();
        test_reset_mid_exec();
        test_random_programs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
